// File: rtl/issue_dispatch.sv
// Issue stage: pulls up to two in-order entries from the issue queue head,
// checks them against a register busy scoreboard and pipe readiness, and loads pipe slots.
package issue_dispatch_pkg;
    typedef struct packed {
        logic [7:0] tag;
        logic [4:0] rs;
        logic [4:0] rt;
        logic [4:0] rd;
        logic       reg_write;
        logic       is_mem;
    } issue_queue_element_t;
endpackage

module issue_dispatch
    import issue_dispatch_pkg::*;
#(
    parameter int NUM_REGS    = 32,
    parameter int STALL_CNT_W = 16
) (
    input  logic                                     clk,
    input  logic                                     rst,
    input  issue_dispatch_pkg::issue_queue_element_t [1:0] iq_data,
    input  logic [1:0]                               iq_size,
    output logic [1:0]                               pop_number,
    output logic [1:0]                               issue_valid,
    output issue_dispatch_pkg::issue_queue_element_t [1:0] issue_data,
    input  logic [1:0]                               pipe_ready,
    input  logic [1:0]                               wb_valid,
    input  logic [1:0][4:0]                          wb_addr,
    input  logic                                     flush,
    output logic [STALL_CNT_W-1:0]                   stall_count
);

    logic [NUM_REGS-1:0] busy_r;
    logic [NUM_REGS-1:0] busy_nxt_s;
    logic [NUM_REGS-1:0] set_s;
    logic [NUM_REGS-1:0] clr_s;
    logic [1:0]          slot_free_s;
    logic [1:0]          issue_s;

    function automatic logic cand0_clear(input logic [NUM_REGS-1:0] busy,
                                         input issue_queue_element_t e);
        return !busy[e.rs] && !busy[e.rt] && (!e.reg_write || !busy[e.rd]);
    endfunction

    // The younger candidate also has to avoid RAW/WAW against the older one issuing alongside it.
    function automatic logic cand1_clear(input logic [NUM_REGS-1:0] busy,
                                         input issue_queue_element_t e0,
                                         input issue_queue_element_t e1);
        logic raw;
        logic waw;
        raw = e0.reg_write && (e0.rd != 5'd0) && ((e1.rs == e0.rd) || (e1.rt == e0.rd));
        waw = e0.reg_write && e1.reg_write && (e0.rd == e1.rd);
        return !busy[e1.rs] && !busy[e1.rt] && !busy[e1.rd] && !raw && !waw;
    endfunction

    // Issue decision for both candidates, strictly in order.
    always_comb begin
        slot_free_s = ~issue_valid | pipe_ready;
        issue_s     = 2'b00;
        if (!rst && !flush && (iq_size != 2'd0)) begin
            issue_s[0] = slot_free_s[0] && cand0_clear(busy_r, iq_data[0]);
            issue_s[1] = issue_s[0] && (iq_size == 2'd2) && slot_free_s[1] &&
                         !iq_data[1].is_mem && cand1_clear(busy_r, iq_data[0], iq_data[1]);
        end else begin
            issue_s = 2'b00;
        end
    end

    assign pop_number = issue_s[1] ? 2'd2 : (issue_s[0] ? 2'd1 : 2'd0);

    // Next scoreboard state: writebacks clear, new issues set, set wins, r0 never busy.
    always_comb begin
        set_s = '0;
        clr_s = '0;
        for (int k = 0; k < 2; k++) begin
            clr_s[wb_addr[k]] = clr_s[wb_addr[k]] | wb_valid[k];
            set_s[iq_data[k].rd] = set_s[iq_data[k].rd] | (issue_s[k] & iq_data[k].reg_write);
        end
        busy_nxt_s    = (busy_r & ~clr_s) | set_s;
        busy_nxt_s[0] = 1'b0;
    end

    // Slot registers, scoreboard and stall counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            issue_valid <= 2'b00;
            issue_data  <= '0;
            busy_r      <= '0;
            stall_count <= '0;
        end else if (flush) begin
            issue_valid <= 2'b00;
            busy_r      <= '0;
        end else begin
            for (int k = 0; k < 2; k++) begin
                if (issue_s[k]) begin
                    issue_valid[k] <= 1'b1;
                    issue_data[k]  <= iq_data[k];
                end else if (pipe_ready[k]) begin
                    issue_valid[k] <= 1'b0;
                end else begin
                    issue_valid[k] <= issue_valid[k];
                end
            end
            busy_r <= busy_nxt_s;
            if ((iq_size != 2'd0) && (pop_number == 2'd0) && (stall_count != {STALL_CNT_W{1'b1}})) begin
                stall_count <= stall_count + {{(STALL_CNT_W-1){1'b0}}, 1'b1};
            end else begin
                stall_count <= stall_count;
            end
        end
    end

endmodule

// File: tb/tb_issue_dispatch.sv
// Directed bench for issue_dispatch: stimulus queues expected slot contents,
// a negedge monitor compares them whenever a pipe accepts a slot.
module tb_issue_dispatch;
    import issue_dispatch_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                       rst, flush;
    logic [1:0]                 iq_size, pipe_ready, wb_valid, pop_number, issue_valid;
    issue_queue_element_t [1:0] iq_data, issue_data;
    logic [1:0][4:0]            wb_addr;
    logic [15:0]                stall_count;

    int total = 0;
    int bad   = 0;
    issue_queue_element_t exp0[$];
    issue_queue_element_t exp1[$];

    issue_dispatch #(.NUM_REGS(32), .STALL_CNT_W(16)) dut (
        .clk(clk), .rst(rst), .iq_data(iq_data), .iq_size(iq_size),
        .pop_number(pop_number), .issue_valid(issue_valid), .issue_data(issue_data),
        .pipe_ready(pipe_ready), .wb_valid(wb_valid), .wb_addr(wb_addr),
        .flush(flush), .stall_count(stall_count)
    );

    function automatic issue_queue_element_t mk(input int tag, input int rs, input int rt,
                                                input int rd, input int rw, input int mem);
        issue_queue_element_t e;
        e.tag = 8'(tag); e.rs = 5'(rs); e.rt = 5'(rt); e.rd = 5'(rd);
        e.reg_write = 1'(rw); e.is_mem = 1'(mem);
        return e;
    endfunction

    function automatic logic [31:0] e2v(input issue_queue_element_t e);
        return {7'd0, e};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic present(input logic [1:0] sz, input issue_queue_element_t a,
                           input issue_queue_element_t b);
        iq_size = sz; iq_data[0] = a; iq_data[1] = b;
    endtask

    // Scoreboard monitor: each accepted slot must match the next queued expectation.
    always @(negedge clk) begin
        if (!rst) begin
            if (issue_valid[0] && pipe_ready[0]) begin
                if (exp0.size() == 0) begin
                    total++; bad++;
                    $display("FAIL slot0_unexpected: got %0h expected none", e2v(issue_data[0]));
                end else begin
                    chk("slot0_data", e2v(issue_data[0]), e2v(exp0.pop_front()));
                end
            end
            if (issue_valid[1] && pipe_ready[1]) begin
                if (exp1.size() == 0) begin
                    total++; bad++;
                    $display("FAIL slot1_unexpected: got %0h expected none", e2v(issue_data[1]));
                end else begin
                    chk("slot1_data", e2v(issue_data[1]), e2v(exp1.pop_front()));
                end
            end
        end
    end

    issue_queue_element_t A, B, C, E, F, G, H, I, J, K, L, N, O, P, Q, R, S, T, Z;

    initial begin
        A = mk(1, 1, 2, 3, 1, 0);   B = mk(2, 4, 5, 6, 1, 0);   C = mk(3, 6, 0, 0, 0, 0);
        E = mk(4, 1, 2, 3, 1, 0);   F = mk(5, 3, 0, 8, 1, 0);   G = mk(6, 9, 10, 11, 1, 0);
        H = mk(7, 12, 13, 14, 1, 1); I = mk(8, 1, 2, 15, 0, 0); J = mk(9, 16, 17, 18, 1, 0);
        K = mk(10, 1, 2, 7, 1, 0);  L = mk(11, 0, 0, 0, 1, 0);  N = mk(12, 0, 0, 0, 0, 0);
        O = mk(13, 7, 0, 0, 0, 0);  P = mk(14, 1, 2, 20, 1, 0); Q = mk(15, 3, 4, 21, 1, 0);
        R = mk(16, 7, 18, 20, 1, 0); S = mk(17, 21, 0, 22, 1, 0); T = mk(18, 20, 0, 0, 0, 0);
        Z = mk(0, 0, 0, 0, 0, 0);

        rst = 1'b1; flush = 1'b0; pipe_ready = 2'b11; wb_valid = 2'b00; wb_addr = '0;
        present(2'd2, A, B);
        #1 chk("pop_in_reset", 32'(pop_number), 32'd0);
        step();
        chk("pop_in_reset2", 32'(pop_number), 32'd0);
        step();
        rst = 1'b0;
        chk("reset_valid", 32'(issue_valid), 32'd0);
        chk("reset_stall", 32'(stall_count), 32'd0);
        chk("reset_data0", e2v(issue_data[0]), 32'd0);

        // Dual issue, no hazards
        #1 chk("t1_pop2", 32'(pop_number), 32'd2);
        exp0.push_back(A); exp1.push_back(B);
        step();
        chk("t1_valid", 32'(issue_valid), 32'd3);
        present(2'd1, C, Z);
        #1 chk("t1_busy6_stall", 32'(pop_number), 32'd0);
        step();
        chk("t1_stall1", 32'(stall_count), 32'd1);
        chk("t1_slots_drained", 32'(issue_valid), 32'd0);
        wb_valid = 2'b10; wb_addr[1] = 5'd6;
        #1 chk("t1_no_wb_bypass", 32'(pop_number), 32'd0);
        step();
        chk("t1_stall2", 32'(stall_count), 32'd2);
        wb_valid = 2'b01; wb_addr[0] = 5'd3;
        #1 chk("t1_after_wb", 32'(pop_number), 32'd1);
        exp0.push_back(C);
        step();
        wb_valid = 2'b00;

        // RAW against older candidate
        present(2'd2, E, F);
        #1 chk("t2_raw_pop1", 32'(pop_number), 32'd1);
        exp0.push_back(E);
        step();
        present(2'd1, F, Z);
        #1 chk("t2_busy3", 32'(pop_number), 32'd0);
        step();
        wb_valid = 2'b01; wb_addr[0] = 5'd3;
        #1 chk("t2_no_bypass", 32'(pop_number), 32'd0);
        step();
        wb_valid = 2'b00;
        chk("t2_stall4", 32'(stall_count), 32'd4);
        #1 chk("t2_issue_after_wb", 32'(pop_number), 32'd1);
        exp0.push_back(F);
        step();

        // Memory op can't go to pipe 1
        present(2'd2, G, H);
        #1 chk("t3_mem_pop1", 32'(pop_number), 32'd1);
        exp0.push_back(G);
        step();
        present(2'd1, H, Z);
        #1 chk("t3_mem_next", 32'(pop_number), 32'd1);
        exp0.push_back(H);
        step();
        chk("t3_valid", 32'(issue_valid), 32'd1);
        present(2'd0, Z, Z);
        wb_valid = 2'b11; wb_addr[0] = 5'd8; wb_addr[1] = 5'd11;
        step();
        wb_addr[0] = 5'd14; wb_addr[1] = 5'd14;
        step();
        wb_valid = 2'b00;
        chk("t3_stall_idle", 32'(stall_count), 32'd4);

        // Backpressure on pipe 0 holds the slot
        pipe_ready = 2'b10;
        present(2'd1, I, Z);
        #1 chk("t4_load", 32'(pop_number), 32'd1);
        exp0.push_back(I);
        step();
        present(2'd1, J, Z);
        for (int c = 0; c < 3; c++) begin
            #1 chk("t4_hold_pop", 32'(pop_number), 32'd0);
            chk("t4_hold_data", e2v(issue_data[0]), e2v(I));
            chk("t4_hold_valid", 32'(issue_valid[0]), 32'd1);
            step();
        end
        chk("t4_stall7", 32'(stall_count), 32'd7);
        pipe_ready = 2'b11;
        #1 chk("t4_ready_issue", 32'(pop_number), 32'd1);
        exp0.push_back(J);
        step();

        // Set beats clear on r7; r0 never becomes busy
        present(2'd2, K, L);
        wb_valid = 2'b01; wb_addr[0] = 5'd7;
        #1 chk("t5_pop2", 32'(pop_number), 32'd2);
        exp0.push_back(K); exp1.push_back(L);
        step();
        wb_valid = 2'b00;
        present(2'd2, N, O);
        #1 chk("t5_r0_free_r7_busy", 32'(pop_number), 32'd1);
        exp0.push_back(N);
        step();
        present(2'd1, O, Z);
        #1 chk("t5_r7_busy", 32'(pop_number), 32'd0);
        step();
        chk("t5_stall8", 32'(stall_count), 32'd8);

        // Flush clears slots and scoreboard
        pipe_ready = 2'b00;
        present(2'd2, P, Q);
        #1 chk("t6_pre_pop2", 32'(pop_number), 32'd2);
        step();
        chk("t6_both_valid", 32'(issue_valid), 32'd3);
        flush = 1'b1;
        present(2'd2, R, S);
        #1 chk("t6_flush_pop0", 32'(pop_number), 32'd0);
        step();
        flush = 1'b0;
        chk("t6_valid_cleared", 32'(issue_valid), 32'd0);
        chk("t6_stall_kept", 32'(stall_count), 32'd8);
        pipe_ready = 2'b11;
        #1 chk("t6_busy_cleared", 32'(pop_number), 32'd2);
        exp0.push_back(R); exp1.push_back(S);
        step();

        // Permanent hazard on r20 drives the counter to saturation
        present(2'd1, T, Z);
        for (int c = 0; c < 70000; c++) step();
        chk("t6_saturate", 32'(stall_count), 32'hFFFF);
        chk("t6_still_blocked", 32'(pop_number), 32'd0);
        present(2'd0, Z, Z);
        step();
        step();
        chk("exp0_drained", 32'(exp0.size()), 32'd0);
        chk("exp1_drained", 32'(exp1.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
